// File: rtl/sap2_computer_if.sv
// Memory bus shared by the SAP-2 CPU, boot ROM and RAM.
interface sap2_computer_if #(
    parameter int DW = 8,
    parameter int AW = 16
);
    // No stall or handshake: the master presents addr/we/wdata every cycle and
    // the slave returns rdata for that address on the following rising edge.
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          we;
    logic [DW-1:0] rdata;

    modport master (output addr, output wdata, output we, input rdata);
    modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/sap2_computer.sv
// SAP-2 style 8-bit computer: CPU core with microcoded control unit, boot ROM
// at F000-FFFF and RAM at 0000-07FF on a shared synchronous-read bus.
package arch_defs_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 16;

    // Any byte not listed here executes as NOP (00).
    localparam logic [DATA_WIDTH-1:0] OP_HLT   = 8'h76;
    localparam logic [DATA_WIDTH-1:0] OP_LDI_A = 8'h3E;
    localparam logic [DATA_WIDTH-1:0] OP_LDI_B = 8'h06;
    localparam logic [DATA_WIDTH-1:0] OP_LDI_C = 8'h0E;
    localparam logic [DATA_WIDTH-1:0] OP_ADD_B = 8'h80;
    localparam logic [DATA_WIDTH-1:0] OP_ADD_C = 8'h81;
    localparam logic [DATA_WIDTH-1:0] OP_SUB_B = 8'h90;
    localparam logic [DATA_WIDTH-1:0] OP_SUB_C = 8'h91;

    typedef enum logic [3:0] {
        ST_RST, ST_BOOT, ST_T0, ST_T1, ST_T2, ST_T3, ST_EX1, ST_EX2, ST_HALT
    } step_t;
endpackage

module sap2_control_unit
    import arch_defs_pkg::*;
#(
    parameter int DW = DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] rdata,
    output step_t         step,
    output logic [DW-1:0] opcode,
    output logic          byte_sel,
    output logic          halt
);
    logic is_ldi;
    logic is_alu;

    always_comb begin
        is_ldi = (opcode == OP_LDI_A) || (opcode == OP_LDI_B) || (opcode == OP_LDI_C);
        is_alu = (opcode == OP_ADD_B) || (opcode == OP_ADD_C) ||
                 (opcode == OP_SUB_B) || (opcode == OP_SUB_C);
    end

    // ST_BOOT idles one cycle so the first fetch begins a full cycle after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step     <= ST_RST;
            opcode   <= '0;
            byte_sel <= 1'b0;
            halt     <= 1'b0;
        end else begin
            case (step)
                ST_RST:  step <= ST_BOOT;
                ST_BOOT: step <= ST_T0;
                ST_T0:   step <= ST_T1;
                ST_T1:   step <= ST_T2;
                ST_T2: begin
                    if (!byte_sel) opcode <= rdata;
                    step <= ST_T3;
                end
                ST_T3: begin
                    if (!byte_sel && is_ldi) begin
                        byte_sel <= 1'b1;
                        step     <= ST_T0;
                    end else begin
                        byte_sel <= 1'b0;
                        step     <= (is_ldi || is_alu || opcode == OP_HLT) ? ST_EX1 : ST_T0;
                    end
                end
                ST_EX1: begin
                    if (opcode == OP_HLT) begin
                        halt <= 1'b1;
                        step <= ST_HALT;
                    end else begin
                        step <= is_alu ? ST_EX2 : ST_T0;
                    end
                end
                ST_EX2:  step <= ST_T0;
                ST_HALT: step <= ST_HALT;
                default: step <= ST_RST;
            endcase
        end
    end
endmodule

module sap2_cpu
    import arch_defs_pkg::*;
#(
    parameter int            DW       = DATA_WIDTH,
    parameter int            AW       = ADDR_WIDTH,
    parameter logic [AW-1:0] ROM_BASE = 16'hF000
) (
    input  logic            clk,
    input  logic            rst_n,
    sap2_computer_if.master bus,
    output logic            halt
);
    step_t         step;
    logic [DW-1:0] opcode;
    logic          byte_sel;
    logic [AW-1:0] counter_out, mar;
    logic [DW-1:0] temp_1_out, a_out, b_out, c_out, alu_r;
    logic          flag_zero_o, flag_negative_o, flag_carry_o, alu_c;
    logic [DW-1:0] operand;
    logic          is_sub, is_ldi;
    logic [DW:0]   alu_sum;
    logic          unused_flags;

    sap2_control_unit #(.DW(DW)) u_control_unit (
        .clk(clk), .rst_n(rst_n), .rdata(bus.rdata),
        .step(step), .opcode(opcode), .byte_sel(byte_sel), .halt(halt)
    );

    assign bus.addr     = mar;
    assign bus.we       = 1'b0;
    assign bus.wdata    = a_out;
    assign unused_flags = flag_zero_o ^ flag_negative_o ^ flag_carry_o;

    // Subtraction is A + ~r + 1, so carry out means "no borrow".
    always_comb begin
        is_ldi  = (opcode == OP_LDI_A) || (opcode == OP_LDI_B) || (opcode == OP_LDI_C);
        is_sub  = (opcode == OP_SUB_B) || (opcode == OP_SUB_C);
        operand = ((opcode == OP_ADD_C) || (opcode == OP_SUB_C)) ? c_out : b_out;
        alu_sum = {1'b0, a_out} + {1'b0, (is_sub ? ~operand : operand)} + {{DW{1'b0}}, is_sub};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_out     <= ROM_BASE;
            mar             <= ROM_BASE;
            temp_1_out      <= '0;
            a_out           <= '0;
            b_out           <= '0;
            c_out           <= '0;
            alu_r           <= '0;
            alu_c           <= 1'b0;
            flag_zero_o     <= 1'b0;
            flag_negative_o <= 1'b0;
            flag_carry_o    <= 1'b0;
        end else begin
            case (step)
                ST_T0: mar <= counter_out;
                ST_T2: if (byte_sel) temp_1_out <= bus.rdata;
                ST_T3: counter_out <= counter_out + AW'(1);
                ST_EX1: begin
                    if (is_ldi) begin
                        flag_zero_o     <= (temp_1_out == '0);
                        flag_negative_o <= temp_1_out[DW-1];
                    end
                    if (opcode == OP_LDI_A) a_out <= temp_1_out;
                    if (opcode == OP_LDI_B) b_out <= temp_1_out;
                    if (opcode == OP_LDI_C) c_out <= temp_1_out;
                    {alu_c, alu_r} <= alu_sum;
                end
                ST_EX2: begin
                    a_out           <= alu_r;
                    flag_zero_o     <= (alu_r == '0);
                    flag_negative_o <= alu_r[DW-1];
                    flag_carry_o    <= alu_c;
                end
                default: ;
            endcase
        end
    end
endmodule

module sap2_rom #(
    parameter int DW    = 8,
    parameter int AW    = 16,
    parameter int DEPTH = 4096
) (
    input logic            clk,
    sap2_computer_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    logic [DW-1:0] mem [DEPTH];
    logic          unused_rom;

    assign unused_rom = ^{bus.addr[AW-1:IW], bus.we, bus.wdata};

    always_ff @(posedge clk) bus.rdata <= mem[bus.addr[IW-1:0]];

    task automatic init_sim_rom();
        for (int i = 0; i < DEPTH; i++) mem[IW'(i)] = '0;
    endtask

    task automatic load_byte(input logic [IW-1:0] off, input logic [DW-1:0] val);
        mem[off] = val;
    endtask
endmodule

module sap2_ram #(
    parameter int DW    = 8,
    parameter int AW    = 16,
    parameter int DEPTH = 2048
) (
    input logic            clk,
    sap2_computer_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    logic [DW-1:0] mem [DEPTH];
    logic          unused_ram;

    assign unused_ram = ^bus.addr[AW-1:IW];

    always_ff @(posedge clk) begin
        if (bus.we) mem[bus.addr[IW-1:0]] <= bus.wdata;
        bus.rdata <= mem[bus.addr[IW-1:0]];
    end

    task automatic init_sim_ram();
        for (int i = 0; i < DEPTH; i++) mem[IW'(i)] <= '0;
    endtask
endmodule

module sap2_computer #(
    parameter int                    DATA_WIDTH = arch_defs_pkg::DATA_WIDTH,
    parameter int                    ADDR_WIDTH = arch_defs_pkg::ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] ROM_BASE   = 16'hF000,
    parameter int                    RAM_DEPTH  = 2048
) (
    input  logic clk,
    input  logic reset,
    output logic halt
);
    localparam int ROM_DEPTH = (1 << ADDR_WIDTH) - int'(ROM_BASE);

    sap2_computer_if #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) cpu_bus ();
    sap2_computer_if #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) rom_bus ();
    sap2_computer_if #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) ram_bus ();

    logic in_rom, in_ram, rd_rom_q, rd_ram_q;

    sap2_cpu #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH), .ROM_BASE(ROM_BASE)) u_cpu (
        .clk(clk), .rst_n(reset), .bus(cpu_bus.master), .halt(halt)
    );
    sap2_rom #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH), .DEPTH(ROM_DEPTH)) u_rom (
        .clk(clk), .bus(rom_bus.slave)
    );
    sap2_ram #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH), .DEPTH(RAM_DEPTH)) u_ram (
        .clk(clk), .bus(ram_bus.slave)
    );

    assign in_rom = (cpu_bus.addr >= ROM_BASE);
    assign in_ram = (cpu_bus.addr < ADDR_WIDTH'(RAM_DEPTH));

    assign rom_bus.addr  = cpu_bus.addr;
    assign rom_bus.wdata = cpu_bus.wdata;
    assign rom_bus.we    = 1'b0;
    assign ram_bus.addr  = cpu_bus.addr;
    assign ram_bus.wdata = cpu_bus.wdata;
    assign ram_bus.we    = cpu_bus.we & in_ram;

    // The select is registered alongside the synchronous read so it lines up with rdata.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_rom_q <= 1'b0;
            rd_ram_q <= 1'b0;
        end else begin
            rd_rom_q <= in_rom;
            rd_ram_q <= in_ram;
        end
    end

    assign cpu_bus.rdata = rd_rom_q ? rom_bus.rdata : (rd_ram_q ? ram_bus.rdata : '0);
endmodule

// File: tb/tb_sap2_computer.sv
// Directed bench for sap2_computer: cycle-exact fetch/execute timing on one
// program, then end-state checks on a table of small ALU programs.
module tb_sap2_computer;
    localparam logic [7:0] OP_LDI_A = 8'h3E;
    localparam logic [7:0] OP_LDI_C = 8'h0E;
    localparam logic [7:0] OP_ADD_C = 8'h81;
    localparam logic [7:0] OP_HLT   = 8'h76;

    logic clk = 1'b0;
    logic reset;
    logic halt;
    int   total = 0;
    int   bad = 0;
    logic [7:0] exp_q[$];

    sap2_computer dut (.clk(clk), .reset(reset), .halt(halt));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_rom(input logic [63:0] prog, input int len);
        dut.u_rom.init_sim_rom();
        for (int i = 0; i < len; i++) dut.u_rom.load_byte(12'(i), prog[63 - 8*i -: 8]);
    endtask

    task automatic wait_halt(input int budget);
        int n;
        n = 0;
        while (halt !== 1'b1 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("halt_seen", 16'(halt), 16'h0001);
    endtask

    task automatic run_prog(input string name, input logic [63:0] prog, input int len,
                            input logic [7:0] ea, input logic ez, input logic en, input logic ec);
        @(negedge clk);
        reset = 1'b0;
        load_rom(prog, len);
        @(negedge clk);
        reset = 1'b1;
        wait_halt(300);
        check({name, "_a"}, 16'(dut.u_cpu.a_out), 16'(ea));
        check({name, "_z"}, 16'(dut.u_cpu.flag_zero_o), 16'(ez));
        check({name, "_n"}, 16'(dut.u_cpu.flag_negative_o), 16'(en));
        check({name, "_c"}, 16'(dut.u_cpu.flag_carry_o), 16'(ec));
        check({name, "_pc"}, dut.u_cpu.counter_out, 16'hF000 + 16'(len));
    endtask

    initial begin
        reset = 1'b0;
        load_rom(64'h3E0A_0E02_8176_0000, 6);
        repeat (2) @(negedge clk);
        check("rst_pc", dut.u_cpu.counter_out, 16'hF000);
        check("rst_a", 16'(dut.u_cpu.a_out), 16'h0000);
        check("rst_temp", 16'(dut.u_cpu.temp_1_out), 16'h0000);
        check("rst_op", 16'(dut.u_cpu.opcode), 16'h0000);
        check("rst_halt", 16'(halt), 16'h0000);

        // Cycle-exact walk through LDI_A 0A, LDI_C 02, ADD_C, HLT.
        exp_q = {OP_LDI_A, OP_LDI_C, OP_ADD_C, OP_HLT};
        @(negedge clk);
        reset = 1'b1;
        step_edges(5);
        check("op_ldi_a", 16'(dut.u_cpu.opcode), 16'(exp_q.pop_front()));
        check("cu_op_mirror", 16'(dut.u_cpu.u_control_unit.opcode), 16'(OP_LDI_A));
        step_edges(4);
        check("temp_0a", 16'(dut.u_cpu.temp_1_out), 16'h000A);
        step_edges(2);
        check("a_0a", 16'(dut.u_cpu.a_out), 16'h000A);
        check("a_0a_z", 16'(dut.u_cpu.flag_zero_o), 16'h0000);
        check("a_0a_n", 16'(dut.u_cpu.flag_negative_o), 16'h0000);
        step_edges(3);
        check("op_ldi_c", 16'(dut.u_cpu.opcode), 16'(exp_q.pop_front()));
        step_edges(4);
        check("temp_02", 16'(dut.u_cpu.temp_1_out), 16'h0002);
        step_edges(2);
        check("c_02", 16'(dut.u_cpu.c_out), 16'h0002);
        step_edges(3);
        check("op_add_c", 16'(dut.u_cpu.opcode), 16'(exp_q.pop_front()));
        step_edges(3);
        check("add_a", 16'(dut.u_cpu.a_out), 16'h000C);
        check("add_z", 16'(dut.u_cpu.flag_zero_o), 16'h0000);
        check("add_n", 16'(dut.u_cpu.flag_negative_o), 16'h0000);
        check("add_c", 16'(dut.u_cpu.flag_carry_o), 16'h0000);
        step_edges(3);
        check("op_hlt", 16'(dut.u_cpu.opcode), 16'(exp_q.pop_front()));
        wait_halt(100);
        check("hlt_pc", dut.u_cpu.counter_out, 16'hF006);
        step_edges(10);
        check("frozen_pc", dut.u_cpu.counter_out, 16'hF006);
        check("frozen_a", 16'(dut.u_cpu.a_out), 16'h000C);
        check("frozen_op", 16'(dut.u_cpu.opcode), 16'(OP_HLT));
        check("frozen_halt", 16'(halt), 16'h0001);

        // Reset while LDI_C's immediate byte is being fetched.
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step_edges(17);
        check("pre_abort_a", 16'(dut.u_cpu.a_out), 16'h000A);
        reset = 1'b0;
        #1;
        check("abort_pc", dut.u_cpu.counter_out, 16'hF000);
        check("abort_a", 16'(dut.u_cpu.a_out), 16'h0000);
        check("abort_op", 16'(dut.u_cpu.opcode), 16'h0000);
        check("abort_halt", 16'(halt), 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        step_edges(5);
        check("restart_op", 16'(dut.u_cpu.opcode), 16'(OP_LDI_A));
        wait_halt(100);
        check("restart_a", 16'(dut.u_cpu.a_out), 16'h000C);
        check("restart_pc", dut.u_cpu.counter_out, 16'hF006);

        // End-state table: name, bytes, length, A, Z, N, C.
        run_prog("sub_eq",     64'h3E05_0605_9076_0000, 6, 8'h00, 1'b1, 1'b0, 1'b1);
        run_prog("add_wrap",   64'h3EFF_0E01_8176_0000, 6, 8'h00, 1'b1, 1'b0, 1'b1);
        run_prog("ldi_keep_c", 64'h3EFF_0E01_813E_8076, 8, 8'h80, 1'b0, 1'b1, 1'b1);
        run_prog("sub_borrow", 64'h3E03_0E05_9176_0000, 6, 8'hFE, 1'b0, 1'b1, 1'b0);
        run_prog("sub_c",      64'h3E0A_0E03_9176_0000, 6, 8'h07, 1'b0, 1'b0, 1'b1);
        run_prog("nop_undef",  64'h3E07_00FF_0609_8076, 8, 8'h10, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
